passcode_controller: RTL and testbench

- Sequencing FSM for the password game's keypad path.
- Collects entered digits into an entry buffer and compares the buffer with a stored passcode.
- Counts failed attempts and enforces a timed lockout after too many failures.
- While unlocked, allows the stored passcode to be reprogrammed.
- Sits between the keypad debouncer/encoder and the display/LED logic.

---
 rtl/passcode_controller.sv | 208 ++++++++++++++++++++
 tb/tb_passcode_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/passcode_controller.sv
// Keypad sequencing FSM for the password game.
// Collects digits into an entry buffer and compares the buffer with a stored
// passcode. It counts failed attempts and holds a timed lockout once the
// attempts run out. While unlocked, the stored passcode can be reprogrammed.
//
// Strobe handshake: key_valid, enter, cancel and relock are single-cycle
// strobes sampled on the rising clock edge, with no back-pressure. At most
// one strobe acts in a cycle. The order is cancel > enter > key_valid, and
// in UNLOCKED relock outranks all of them. A strobe that has no meaning in
// the current state still uses up that cycle, so a lower-priority strobe in
// the same cycle is dropped.
module passcode_controller #(
    parameter int                           DIGITS      = 4,
    parameter int                           DIGIT_W     = 4,
    parameter int                           MAX_TRIES   = 3,
    parameter int                           LOCK_CYCLES = 16,
    parameter logic [DIGITS*DIGIT_W-1:0]    DEFAULT_PW  = 16'h1234
) (
    input  logic                            clk,
    input  logic                            clr_n,
    input  logic                            key_valid,
    input  logic [DIGIT_W-1:0]              key_digit,
    input  logic                            enter,
    input  logic                            cancel,
    input  logic                            relock,
    input  logic                            prog,
    output logic [DIGITS*DIGIT_W-1:0]       entry_value,
    output logic [$clog2(DIGITS+1)-1:0]     entry_count,
    output logic                            unlocked,
    output logic                            fail_pulse,
    output logic                            locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]  tries_left,
    output logic [2:0]                      state
);

    localparam int PW_W  = DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [TRY_W-1:0] TRY_MAX   = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRY_ONE   = TRY_W'(1);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(LOCK_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_CHECK    = 3'd2,
        S_UNLOCKED = 3'd3,
        S_FAIL     = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [PW_W-1:0]    value_d;
    logic [CNT_W-1:0]   count_d;
    logic [PW_W-1:0]    stored_pw, pw_d;
    logic [TRY_W-1:0]   tries_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               accept;
    logic [PW_W-1:0]    shifted;

    // A digit can only be taken while the buffer still has room.
    assign accept  = key_valid && (entry_count < CNT_FULL);
    // The first digit entered ends up in the MSBs after DIGITS shifts.
    assign shifted = {entry_value[PW_W-DIGIT_W-1:0], key_digit};
    assign state   = state_q;

    // Next-state and next-datapath decisions for every register.
    always_comb begin
        state_d = state_q;
        value_d = entry_value;
        count_d = entry_count;
        pw_d    = stored_pw;
        tries_d = tries_left;
        timer_d = timer_q;

        case (state_q)
            S_IDLE: begin
                // cancel and enter do nothing here, but they still take the cycle.
                if (!cancel && !enter && accept) begin
                    value_d = shifted;
                    count_d = entry_count + CNT_ONE;
                    state_d = S_ENTRY;
                end
            end

            S_ENTRY: begin
                if (cancel) begin
                    value_d = '0;
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (enter) begin
                    // A short entry fails straight away and skips the compare.
                    state_d = (entry_count == CNT_FULL) ? S_CHECK : S_FAIL;
                end else if (accept) begin
                    value_d = shifted;
                    count_d = entry_count + CNT_ONE;
                end
            end

            S_CHECK: begin
                if (entry_value == stored_pw) begin
                    value_d = '0;
                    count_d = '0;
                    tries_d = TRY_MAX;
                    state_d = S_UNLOCKED;
                end else begin
                    state_d = S_FAIL;
                end
            end

            S_FAIL: begin
                value_d = '0;
                count_d = '0;
                // When the last try is used, the lockout starts.
                if (tries_left <= TRY_ONE) begin
                    tries_d = '0;
                    timer_d = TMR_LOAD;
                    state_d = S_LOCKOUT;
                end else begin
                    tries_d = tries_left - TRY_ONE;
                    state_d = S_IDLE;
                end
            end

            S_LOCKOUT: begin
                // Every input is ignored. The timer runs from LOCK_CYCLES down to 1.
                if (timer_q <= TMR_ONE) begin
                    timer_d = '0;
                    tries_d = TRY_MAX;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end

            S_UNLOCKED: begin
                if (relock) begin
                    value_d = '0;
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (cancel) begin
                    value_d = '0;
                    count_d = '0;
                end else if (enter) begin
                    // The passcode is reprogrammed only from a full entry with prog held.
                    if (prog && (entry_count == CNT_FULL)) begin
                        pw_d    = entry_value;
                        value_d = '0;
                        count_d = '0;
                    end
                end else if (accept) begin
                    value_d = shifted;
                    count_d = entry_count + CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: entry buffer, stored passcode, try counter, lockout timer.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            entry_value <= '0;
            entry_count <= '0;
            stored_pw   <= DEFAULT_PW;
            tries_left  <= TRY_MAX;
            timer_q     <= '0;
        end else begin
            entry_value <= value_d;
            entry_count <= count_d;
            stored_pw   <= pw_d;
            tries_left  <= tries_d;
            timer_q     <= timer_d;
        end
    end

    // Status flags are registered from the next state, so each one tracks
    // the state register exactly and comes straight from a flop.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            unlocked   <= 1'b0;
            fail_pulse <= 1'b0;
            locked     <= 1'b0;
        end else begin
            unlocked   <= (state_d == S_UNLOCKED);
            fail_pulse <= (state_d == S_FAIL);
            locked     <= (state_d == S_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_passcode_controller.sv
// Directed bench for passcode_controller. It checks unlock, wrong-code
// lockout, overflow, short entry, simultaneous strobes, reprogramming, and
// an asynchronous reset during lockout.
module tb_passcode_controller;

    logic        clk;
    logic        clr_n;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        enter;
    logic        cancel;
    logic        relock;
    logic        prog;
    logic [15:0] entry_value;
    logic [2:0]  entry_count;
    logic        unlocked;
    logic        fail_pulse;
    logic        locked;
    logic [1:0]  tries_left;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    int lock_cnt;

    passcode_controller dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .enter       (enter),
        .cancel      (cancel),
        .relock      (relock),
        .prog        (prog),
        .entry_value (entry_value),
        .entry_count (entry_count),
        .unlocked    (unlocked),
        .fail_pulse  (fail_pulse),
        .locked      (locked),
        .tries_left  (tries_left),
        .state       (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change and outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic press_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic press_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic press_relock();
        relock = 1'b1;
        tick();
        relock = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code);
        press_key(code[15:12]);
        press_key(code[11:8]);
        press_key(code[7:4]);
        press_key(code[3:0]);
    endtask

    initial begin
        clr_n     = 1'b0;
        key_valid = 1'b0;
        key_digit = '0;
        enter     = 1'b0;
        cancel    = 1'b0;
        relock    = 1'b0;
        prog      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_value", entry_value, 0);
        check("rst_count", entry_count, 0);
        check("rst_tries", tries_left, 3);
        check("rst_flags", {unlocked, fail_pulse, locked}, 0);
        @(negedge clk);
        clr_n = 1'b1;
        tick();

        // correct code unlocks
        enter_code(16'h1234);
        check("full_value", entry_value, 16'h1234);
        check("full_count", entry_count, 4);
        press_enter();
        check("check_state", state, 2);
        check("check_unlk", unlocked, 0);
        tick();
        check("unlk_flag", unlocked, 1);
        check("unlk_state", state, 3);
        check("unlk_tries", tries_left, 3);
        check("unlk_count", entry_count, 0);
        // cancel in UNLOCKED clears the entry and keeps the state
        press_key(4'd5);
        check("unlk_key", entry_count, 1);
        press_cancel();
        check("unlk_cancel_cnt", entry_count, 0);
        check("unlk_cancel_st", state, 3);
        press_relock();
        check("relock_state", state, 0);
        check("relock_unlk", unlocked, 0);

        // three wrong attempts lead to lockout
        for (int a = 0; a < 3; a++) begin
            enter_code(16'h1235);
            press_enter();
            check("wrong_check", state, 2);
            tick();
            check("wrong_fail", fail_pulse, 1);
            check("wrong_fstate", state, 4);
            tick();
            check("wrong_pulse_end", fail_pulse, 0);
            check("wrong_tries", tries_left, 2 - a);
        end
        check("lock_state", state, 5);
        check("lock_flag", locked, 1);
        check("lock_count0", entry_count, 0);
        // key and enter are ignored throughout the lockout
        lock_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            key_valid = 1'b1;
            key_digit = 4'd7;
            enter     = i[0];
            tick();
            if (!locked) break;
            lock_cnt++;
        end
        key_valid = 1'b0;
        enter     = 1'b0;
        check("lock_len", lock_cnt, 16);
        check("lock_exit_state", state, 0);
        check("lock_exit_tries", tries_left, 3);
        check("lock_exit_count", entry_count, 0);
        check("lock_exit_value", entry_value, 0);

        // overflow is ignored, a short entry fails
        enter_code(16'h1234);
        press_key(4'd9);
        check("ovf_value", entry_value, 16'h1234);
        check("ovf_count", entry_count, 4);
        press_cancel();
        check("cancel_state", state, 0);
        check("cancel_count", entry_count, 0);
        check("cancel_tries", tries_left, 3);
        press_key(4'd1);
        press_key(4'd2);
        press_enter();
        check("short_state", state, 4);
        check("short_fail", fail_pulse, 1);
        tick();
        check("short_tries", tries_left, 2);
        check("short_idle", state, 0);

        // simultaneous strobes: cancel wins
        enter_code(16'h1234);
        cancel    = 1'b1;
        enter     = 1'b1;
        key_valid = 1'b1;
        key_digit = 4'd8;
        tick();
        cancel    = 1'b0;
        enter     = 1'b0;
        key_valid = 1'b0;
        check("simul_state", state, 0);
        check("simul_count", entry_count, 0);
        check("simul_value", entry_value, 0);
        check("simul_tries", tries_left, 2);
        check("simul_fail", fail_pulse, 0);
        tick();
        check("simul_fail2", fail_pulse, 0);

        // reprogram to 9876
        enter_code(16'h1234);
        press_enter();
        tick();
        check("rp_unlk", unlocked, 1);
        check("rp_tries", tries_left, 3);
        prog = 1'b1;
        enter_code(16'h9876);
        press_enter();
        prog = 1'b0;
        check("rp_store_cnt", entry_count, 0);
        check("rp_store_st", state, 3);
        press_relock();
        enter_code(16'h9876);
        press_enter();
        tick();
        check("rp_new_unlk", unlocked, 1);
        press_relock();
        enter_code(16'h1234);
        press_enter();
        tick();
        check("rp_old_fail", fail_pulse, 1);
        tick();
        check("rp_old_tries", tries_left, 2);

        // async reset during lockout
        for (int a = 0; a < 2; a++) begin
            enter_code(16'h1111);
            press_enter();
            tick();
            tick();
        end
        check("ar_locked", locked, 1);
        tick();
        tick();
        #2;
        clr_n = 1'b0;
        #1;
        check("ar_lock_clr", locked, 0);
        check("ar_state", state, 0);
        check("ar_tries", tries_left, 3);
        #2;
        clr_n = 1'b1;
        tick();
        enter_code(16'h1234);
        press_enter();
        tick();
        check("ar_default_pw", unlocked, 1);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
